// File: rtl/nibble_seq_adder.sv
// nibble_seq_adder: WIDTH-bit adder sequenced over one owned adder_4bit, LS nibble first.
// Optional signed-overflow output is enabled with `define NSA_OVERFLOW_EN.

module adder_4bit (
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       cin,
    output logic [3:0] sum,
    output logic       cout
);
    assign {cout, sum} = {1'b0, a} + {1'b0, b} + {4'b0000, cin};
endmodule

module nibble_seq_adder #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout
`ifdef NSA_OVERFLOW_EN
    ,
    output logic             ovf
`endif
);
    localparam int N  = WIDTH / 4;
    localparam int KW = (N > 1) ? $clog2(N) : 1;
    localparam logic [KW-1:0] K_LAST = KW'(N - 1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state;
    state_t           state_nx;
    logic [KW-1:0]    k;
    logic [WIDTH-1:0] a_r;
    logic [WIDTH-1:0] b_r;
    logic [WIDTH-1:0] sum_r;
    logic             carry_r;
    logic             accept;
    logic             last;
    logic [3:0]       nib_a;
    logic [3:0]       nib_b;
    logic [3:0]       nib_sum;
    logic             nib_cout;

    assign nib_a = a_r[{k, 2'b00} +: 4];
    assign nib_b = b_r[{k, 2'b00} +: 4];
    assign last  = (k == K_LAST);

    adder_4bit u_adder (
        .a    (nib_a),
        .b    (nib_b),
        .cin  (carry_r),
        .sum  (nib_sum),
        .cout (nib_cout)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx  = state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        accept    = 1'b0;
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    accept   = 1'b1;
                    state_nx = RUN;
                end
            end
            RUN: begin
                if (last) state_nx = DONE;
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    // carry_r doubles as the captured cin and the inter-nibble carry
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_r     <= '0;
            b_r     <= '0;
            sum_r   <= '0;
            carry_r <= 1'b0;
            k       <= '0;
        end else if (accept) begin
            a_r     <= a;
            b_r     <= b;
            carry_r <= cin;
            k       <= '0;
        end else if (state == RUN) begin
            sum_r[{k, 2'b00} +: 4] <= nib_sum;
            carry_r                <= nib_cout;
            k                      <= last ? '0 : k + 1'b1;
        end
    end

`ifdef NSA_OVERFLOW_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ovf <= 1'b0;
        end else if (state == RUN && last) begin
            ovf <= (a_r[WIDTH-1] ~^ b_r[WIDTH-1]) & (a_r[WIDTH-1] ^ nib_sum[3]);
        end
    end
`endif

    assign sum  = sum_r;
    assign cout = carry_r;

endmodule
